// File: rtl/pmsm_model.sv
// rtl/pmsm_model.sv - fixed-point PMSM plant model with sampled current/speed/angle outputs; optional measurement noise under PMSM_NOISE_EN
module pmsm_model #(
    parameter int N          = 32,
    parameter int Q          = 18,
    parameter int C_TL       = 124,
    parameter int C_RTL      = 183,
    parameter int C_LTL      = 25,
    parameter int C_T        = 3,
    parameter int C_TE       = 3187,
    parameter int C_BJ       = 1,
    parameter int C_TJ       = 2621,
    parameter int TWO_PI     = 1647099,
    parameter int OMEGA_INIT = 0,
    parameter int THETA_INIT = 0,
    parameter int NOISE_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [N-1:0] valpha,
    input  logic signed [N-1:0] vbeta,
    input  logic signed [N-1:0] tload,
    input  logic signed [N-1:0] stheta,
    input  logic signed [N-1:0] ctheta,
    input  logic        [N-1:0] nbSamples,
    input  logic                enable,
    output logic signed [N-1:0] ialpham,
    output logic signed [N-1:0] ibetam,
    output logic signed [N-1:0] omega_true,
    output logic signed [N-1:0] theta_true,
    output logic                sample_valid
);

    localparam logic signed [N-1:0] L_TL     = N'(C_TL);
    localparam logic signed [N-1:0] L_RTL    = N'(C_RTL);
    localparam logic signed [N-1:0] L_LTL    = N'(C_LTL);
    localparam logic signed [N-1:0] L_T      = N'(C_T);
    localparam logic signed [N-1:0] L_TE     = N'(C_TE);
    localparam logic signed [N-1:0] L_BJ     = N'(C_BJ);
    localparam logic signed [N-1:0] L_TJ     = N'(C_TJ);
    localparam logic signed [N-1:0] L_TWO_PI = N'(TWO_PI);
    localparam logic signed [N-1:0] L_OMEGA0 = N'(OMEGA_INIT);
    localparam logic signed [N-1:0] L_THETA0 = N'(THETA_INIT);
    localparam logic [3:0]          LAST_STEP = 4'd12;

    typedef enum logic [1:0] {WAIT, CALC, UPDATE} state_t;

    state_t              r_state;
    logic        [N-1:0] r_count;
    logic        [3:0]   r_step;
    logic signed [N-1:0] r_ia, r_ib, r_omega, r_theta;
    logic signed [N-1:0] r_va, r_vb, r_tl, r_s, r_c;
    logic signed [N-1:0] r_m [0:12];

    logic                w_fire;
    logic signed [N-1:0] w_a, w_b, w_qm;
    logic signed [2*N-1:0] w_prod;
    logic signed [N-1:0] w_ia_new, w_ib_new, w_omega_new, w_theta_sum, w_theta_new;
    logic signed [N-1:0] w_ia_meas, w_ib_meas;

    assign w_fire = (r_count >= nbSamples);

    // Operand select for the single shared multiplier, one product per CALC step
    always_comb begin
        w_a = '0;
        w_b = '0;
        case (r_step)
            4'd0:    begin w_a = L_LTL;   w_b = r_omega;           end
            4'd1:    begin w_a = r_m[0];  w_b = r_s;               end
            4'd2:    begin w_a = r_m[0];  w_b = r_c;               end
            4'd3:    begin w_a = L_RTL;   w_b = r_ia;              end
            4'd4:    begin w_a = L_RTL;   w_b = r_ib;              end
            4'd5:    begin w_a = L_TL;    w_b = r_va;              end
            4'd6:    begin w_a = L_TL;    w_b = r_vb;              end
            4'd7:    begin w_a = r_ib;    w_b = r_c;               end
            4'd8:    begin w_a = r_ia;    w_b = r_s;               end
            4'd9:    begin w_a = L_TE;    w_b = r_m[7] - r_m[8];   end
            4'd10:   begin w_a = L_BJ;    w_b = r_omega;           end
            4'd11:   begin w_a = L_TJ;    w_b = r_tl;              end
            4'd12:   begin w_a = r_omega; w_b = L_T;               end
            default: begin w_a = '0;      w_b = '0;                end
        endcase
    end

    assign w_prod = w_a * w_b;
    assign w_qm   = N'(w_prod >>> Q);

    assign w_ia_new    = r_ia + r_m[5] - r_m[3] + r_m[1];
    assign w_ib_new    = r_ib + r_m[6] - r_m[4] - r_m[2];
    assign w_omega_new = r_omega + r_m[9] - r_m[10] - r_m[11];
    assign w_theta_sum = r_theta + r_m[12];
    // A single add/subtract is enough since |omega*Ts| stays well under 2*pi
    assign w_theta_new = (w_theta_sum >= L_TWO_PI) ? (w_theta_sum - L_TWO_PI) :
                         (w_theta_sum < 0)         ? (w_theta_sum + L_TWO_PI) :
                                                     w_theta_sum;

`ifdef PMSM_NOISE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_next;

    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_ia_meas   = w_ia_new + N'($signed(w_lfsr_next[NOISE_BITS-1:0]));
    assign w_ib_meas   = w_ib_new + N'($signed(w_lfsr_next[15:16-NOISE_BITS]));

    // Noise generator steps once per published sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lfsr <= 16'hACE1;
        else if (r_state == UPDATE)
            r_lfsr <= w_lfsr_next;
    end
`else
    assign w_ia_meas = w_ia_new;
    assign w_ib_meas = w_ib_new;
`endif

    // Input snapshot at sample start and per-step product storage
    always_ff @(posedge clk) begin
        if (r_state == WAIT && enable && w_fire) begin
            r_va <= valpha;
            r_vb <= vbeta;
            r_tl <= tload;
            r_s  <= stheta;
            r_c  <= ctheta;
        end
        if (r_state == CALC)
            r_m[r_step] <= w_qm;
    end

    // Sample sequencer, plant state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= WAIT;
            r_count      <= '0;
            r_step       <= '0;
            r_ia         <= '0;
            r_ib         <= '0;
            r_omega      <= L_OMEGA0;
            r_theta      <= L_THETA0;
            ialpham      <= '0;
            ibetam       <= '0;
            omega_true   <= L_OMEGA0;
            theta_true   <= L_THETA0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (r_state)
                WAIT: begin
                    if (enable) begin
                        if (w_fire) begin
                            r_count <= '0;
                            r_step  <= '0;
                            r_state <= CALC;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (r_step == LAST_STEP)
                        r_state <= UPDATE;
                    else
                        r_step <= r_step + 1'b1;
                end
                UPDATE: begin
                    r_ia         <= w_ia_new;
                    r_ib         <= w_ib_new;
                    r_omega      <= w_omega_new;
                    r_theta      <= w_theta_new;
                    ialpham      <= w_ia_meas;
                    ibetam       <= w_ib_meas;
                    omega_true   <= w_omega_new;
                    theta_true   <= w_theta_new;
                    sample_valid <= 1'b1;
                    r_state      <= WAIT;
                end
                default: r_state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pmsm_model.sv
// tb/tb_pmsm_model.sv - directed bench for pmsm_model (cadence, vectors, wrap, enable, reset, noise)
module tb_pmsm_model;
    localparam int N = 32;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic signed [N-1:0] valpha, vbeta, tload, stheta, ctheta;
    logic        [N-1:0] nbSamples;
    logic                enable;

    logic signed [N-1:0] m_ia, m_ib, m_om, m_th;
    logic                m_sv;
    logic signed [N-1:0] f_ia, f_ib, f_om, f_th;
    logic                f_sv;
    logic signed [N-1:0] b_ia, b_ib, b_om, b_th;
    logic                b_sv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmsm_model u_main (
        .clk(clk), .reset(reset), .valpha(valpha), .vbeta(vbeta), .tload(tload),
        .stheta(stheta), .ctheta(ctheta), .nbSamples(nbSamples), .enable(enable),
        .ialpham(m_ia), .ibetam(m_ib), .omega_true(m_om), .theta_true(m_th), .sample_valid(m_sv)
    );

    pmsm_model #(.OMEGA_INIT(262144000), .THETA_INIT(1647098)) u_fwd (
        .clk(clk), .reset(reset), .valpha(valpha), .vbeta(vbeta), .tload(tload),
        .stheta(stheta), .ctheta(ctheta), .nbSamples(nbSamples), .enable(enable),
        .ialpham(f_ia), .ibetam(f_ib), .omega_true(f_om), .theta_true(f_th), .sample_valid(f_sv)
    );

    pmsm_model #(.OMEGA_INIT(-262144000), .THETA_INIT(0)) u_bwd (
        .clk(clk), .reset(reset), .valpha(valpha), .vbeta(vbeta), .tload(tload),
        .stheta(stheta), .ctheta(ctheta), .nbSamples(nbSamples), .enable(enable),
        .ialpham(b_ia), .ibetam(b_ib), .omega_true(b_om), .theta_true(b_th), .sample_valid(b_sv)
    );

    typedef struct {
        string               name;
        logic signed [N-1:0] va, vb, tl, s, c;
        logic signed [N-1:0] e_ia, e_ib, e_om, e_th;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic signed [N-1:0] act, input logic signed [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_after(input int k);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < k; i++)
            l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return l;
    endfunction

    // Expected measurement noise on sample k after reset (zero without the noise build)
    function automatic logic signed [N-1:0] noise_a(input int k);
`ifdef PMSM_NOISE_EN
        logic [15:0] l;
        logic [7:0]  b;
        l = lfsr_after(k);
        b = l[7:0];
        return N'($signed(b));
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    function automatic logic signed [N-1:0] noise_b(input int k);
`ifdef PMSM_NOISE_EN
        logic [15:0] l;
        logic [7:0]  b;
        l = lfsr_after(k);
        b = l[15:8];
        return N'($signed(b));
`else
        return (k < 0) ? 1 : 0;
`endif
    endfunction

    task automatic set_in(input logic signed [N-1:0] va, vb, tl, s, c);
        valpha = va; vbeta = vb; tload = tl; stheta = s; ctheta = c;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_sv && n < 300);
    endtask

    int n;

    initial begin
        vecs[0] = '{"va_pos",   2621440, 0, 0, 0, 0,             1240,    0,     0, 0};
        vecs[1] = '{"vb_pos",   0, 2621440, 0, 0, 0,             0,       1240,  0, 0};
        vecs[2] = '{"va_neg",   -2621440, 0, 0, 0, 0,            -1240,   0,     0, 0};
        vecs[3] = '{"tl_pos",   0, 0, 262144, 0, 0,              0,       0, -2621, 0};
        vecs[4] = '{"tl_neg",   0, 0, -524288, 0, 0,             0,       0,  5242, 0};
        vecs[5] = '{"va_trunc", 100000, 0, 0, 0, 0,              47,      0,     0, 0};
        vecs[6] = '{"va_floor", -100000, 100000, 0, 262144, 262144, -48,  47,    0, 0};

        set_in(0, 0, 0, 0, 0);
        nbSamples = 5;
        enable = 1'b1;
        #1 reset = 1'b1;
        @(negedge clk);

        // Reset state of all three plants
        chk("rst_ia", m_ia, 0);
        chk("rst_ib", m_ib, 0);
        chk("rst_om", m_om, 0);
        chk("rst_th", m_th, 0);
        chk("rst_sv", N'(m_sv), 0);
        chk("rst_fwd_om", f_om, 262144000);
        chk("rst_fwd_th", f_th, 1647098);
        chk("rst_bwd_om", b_om, -262144000);

        // Cadence with zero inputs, plus theta wrap in both directions
        do_reset();
        wait_pulse(n);
        chk("cad_first", n, 20);
        chk("cad_ia", m_ia, noise_a(1));
        chk("cad_ib", m_ib, noise_b(1));
        chk("cad_om", m_om, 0);
        chk("cad_th", m_th, 0);
        chk("fwd_th", f_th, 2999);
        chk("fwd_om", f_om, 262143000);
        chk("bwd_th", b_th, 1644099);
        chk("bwd_om", b_om, -262143000);
        @(negedge clk);
        chk("cad_width", N'(m_sv), 0);
        wait_pulse(n);
        chk("cad_period", n, 19);
        chk("cad2_ia", m_ia, noise_a(2));
        chk("cad2_om", m_om, 0);
        chk("fwd2_th", f_th, 5998);
        chk("fwd2_om", f_om, 262142001);

        // First-sample response for each vector
        for (int i = 0; i < 7; i++) begin
            set_in(vecs[i].va, vecs[i].vb, vecs[i].tl, vecs[i].s, vecs[i].c);
            do_reset();
            wait_pulse(n);
            chk({vecs[i].name, "_cyc"}, n, 20);
            chk({vecs[i].name, "_ia"}, m_ia, vecs[i].e_ia + noise_a(1));
            chk({vecs[i].name, "_ib"}, m_ib, vecs[i].e_ib + noise_b(1));
            chk({vecs[i].name, "_om"}, m_om, vecs[i].e_om);
            chk({vecs[i].name, "_th"}, m_th, vecs[i].e_th);
        end

        // Three samples: current feedback, torque path, backward wrap from small omega
        set_in(2621440, 0, 0, 262144, 0);
        do_reset();
        wait_pulse(n);
        chk("ms1_ia", m_ia, 1240 + noise_a(1));
        wait_pulse(n);
        chk("ms2_ia", m_ia, 2480 + noise_a(2));
        chk("ms2_om", m_om, -16);
        wait_pulse(n);
        chk("ms3_ia", m_ia, 3718 + noise_a(3));
        chk("ms3_ib", m_ib, 0 + noise_b(3));
        chk("ms3_om", m_om, -46);
        chk("ms3_th", m_th, 1647098);

        // nbSamples=0 period and inputs changed right after the latch edge
        nbSamples = 0;
        set_in(2621440, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        set_in(-2621440, 2621440, 0, 0, 0);
        wait_pulse(n);
        chk("nb0_first", n, 14);
        chk("late_ia", m_ia, 1240 + noise_a(1));
        chk("late_ib", m_ib, 0 + noise_b(1));
        wait_pulse(n);
        chk("nb0_period", n, 15);
        chk("new_ia", m_ia, 0 + noise_a(2));
        chk("new_ib", m_ib, 1240 + noise_b(2));

        // Enable held low, then enable ignored during CALC
        nbSamples = 5;
        enable = 1'b0;
        set_in(2621440, 0, 0, 0, 0);
        do_reset();
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (m_sv) n++;
        end
        chk("en_low_pulses", n, 0);
        enable = 1'b1;
        wait_pulse(n);
        chk("en_resume", n, 20);
        chk("en_ia", m_ia, 1240 + noise_a(1));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 8) enable = 1'b0;
        end while (!m_sv && n < 300);
        chk("en_ignored_calc", n, 20);
        chk("en2_ia", m_ia, 2480 + noise_a(2));

        // Reset at CALC step 6 aborts the sample immediately
        enable = 1'b1;
        repeat (12) @(negedge clk);
        chk("hold_ia", m_ia, 2480 + noise_a(2));
        reset = 1'b1;
        #1;
        chk("abort_ia", m_ia, 0);
        chk("abort_ib", m_ib, 0);
        chk("abort_om", m_om, 0);
        chk("abort_th", m_th, 0);
        chk("abort_sv", N'(m_sv), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_pulse(n);
        chk("abort_next", n, 20);
        chk("abort_next_ia", m_ia, 1240 + noise_a(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
